// File: rtl/mmio_responder.sv
// Memory-mapped TX FIFO responder on the dmem bus. It decodes a 256-word window
// holding TXDATA, STATUS, a free-running CYCLES counter and CTRL, and raises an interrupt when the FIFO drains.
module mmio_responder #(
  parameter logic [11:0] BASE_ADDR  = 12'hF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_mmio,
  output logic        hit,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow, r_drained, r_irq_en, r_irq, r_hit;
  logic [31:0]   r_cycles, r_q;

  logic        w_hit, w_wr, w_full, w_empty;
  logic        w_push, w_pop, w_push_acc, w_push_drop, w_flush;
  logic        w_wr_stat, w_wr_cyc, w_wr_ctrl;
  logic [7:0]  w_off;
  logic [31:0] w_rdata;

  assign w_hit     = (address_dmem[11:8] == BASE_ADDR[11:8]);
  assign w_off     = address_dmem[7:0];
  assign w_wr      = wren & w_hit;
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_wr_stat = w_wr & (w_off == 8'd1);
  assign w_wr_cyc  = w_wr & (w_off == 8'd2);
  assign w_wr_ctrl = w_wr & (w_off == 8'd3);
  assign w_flush   = w_wr_ctrl & data[1];

  assign w_push      = w_wr & (w_off == 8'd0);
  assign w_pop       = ~w_empty & out_ready;
  // A push into a full FIFO still fits if the head leaves on the same edge.
  assign w_push_acc  = w_push & (~w_full | w_pop);
  assign w_push_drop = w_push & w_full & ~w_pop;

  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign q_mmio    = r_q;
  assign hit       = r_hit;
  assign irq       = r_irq;

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        8'd1:    w_rdata = {21'd0, r_overflow, w_empty, w_full, 1'b0, 7'(r_count)};
        8'd2:    w_rdata = r_cycles;
        8'd3:    w_rdata = {31'd0, r_irq_en};
        default: w_rdata = '0;
      endcase
    end
  end

  // Storage is deliberately not reset; out_data is meaningless while empty.
  always_ff @(posedge clock) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drained  <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
      r_cycles   <= '0;
      r_q        <= '0;
      r_hit      <= 1'b0;
    end else begin
      r_q   <= w_rdata;
      r_hit <= w_hit;
      r_irq <= r_irq_en & r_drained;

      if (w_wr_cyc) r_cycles <= data;
      else          r_cycles <= r_cycles + 32'd1;

      if (w_wr_ctrl) r_irq_en <= data[0];

      if (w_push_drop)                r_overflow <= 1'b1;
      else if (w_wr_stat && data[10]) r_overflow <= 1'b0;

      if (w_flush) begin
        r_count   <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_drained <= 1'b0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push_acc, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_push_acc)                      r_drained <= 1'b0;
        else if (w_pop && r_count == CW'(1)) r_drained <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios followed by random bus traffic.
// Every cycle is checked against a queue-based behavioural model.
module tb_mmio_responder;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] q_mmio, out_data;
  logic        hit, out_valid, irq;

  mmio_responder #(.BASE_ADDR(12'hF00), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_mmio(q_mmio), .hit(hit), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_q [$];
  bit          m_ovf, m_drained, m_irq_en;
  logic [31:0] m_cycles;
  logic [31:0] e_q;
  bit          e_hit, e_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one bus cycle, advance the model by the rules, then compare after the edge.
  task automatic cyc(input bit rst_n, input logic [11:0] a, input logic [31:0] d,
                     input bit we, input bit rdy);
    logic [7:0] off;
    bit in_win, pop, push, flush, wr;
    int sz;
    reset = rst_n; address_dmem = a; data = d; wren = we; out_ready = rdy;
    off = a[7:0];
    in_win = (a[11:8] == 4'hF);
    wr = we && in_win;
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_drained = 0; m_irq_en = 0; m_cycles = 0;
      e_q = 0; e_hit = 0; e_irq = 0;
    end else begin
      sz = m_q.size();
      e_hit = in_win;
      e_q = 0;
      if (in_win) begin
        if (off == 8'd1)
          e_q = {21'd0, m_ovf, (sz == 0), (sz == DEPTH), 1'b0, 7'(sz)};
        else if (off == 8'd2)
          e_q = m_cycles;
        else if (off == 8'd3)
          e_q = {31'd0, m_irq_en};
      end
      e_irq = m_irq_en && m_drained;
      pop   = rdy && (sz > 0);
      push  = wr && (off == 8'd0);
      flush = wr && (off == 8'd3) && d[1];
      if (flush) begin
        m_q.delete();
        m_drained = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back(d);
            m_drained = 0;
          end else begin
            m_ovf = 1;
          end
        end
        if (pop && m_q.size() == 0) m_drained = 1;
      end
      if (wr && off == 8'd1 && d[10]) m_ovf = 0;
      m_cycles = (wr && off == 8'd2) ? d : m_cycles + 32'd1;
      if (wr && off == 8'd3) m_irq_en = d[0];
    end
    @(posedge clock);
    #1;
    check("q_mmio", q_mmio, e_q);
    check("hit", 32'(hit), 32'(e_hit));
    check("irq", 32'(irq), 32'(e_irq));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_data", out_data, m_q[0]);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b1, 12'h000, 32'h0, 1'b0, rdy);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    int sel, phase;
    bit rst_n, we, rdy;

    cyc(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 12'hF00, 32'h1, 1'b1, 1'b1);

    // Ordered drain after three pushes
    cyc(1'b1, 12'hF00, 32'hA, 1'b1, 1'b0);
    cyc(1'b1, 12'hF00, 32'hB, 1'b1, 1'b0);
    cyc(1'b1, 12'hF00, 32'hC, 1'b1, 1'b0);
    check("fwft_a", out_data, 32'hA);
    idle(1'b1);
    check("fwft_b", out_data, 32'hB);
    idle(1'b1);
    check("fwft_c", out_data, 32'hC);
    idle(1'b1);
    check("drain_empty", 32'(out_valid), 32'h0);

    // Overflow on the ninth push, then clear it
    for (int i = 0; i < 9; i++) cyc(1'b1, 12'hF00, 32'h100 + i, 1'b1, 1'b0);
    cyc(1'b1, 12'hF01, 32'h0, 1'b0, 1'b0);
    check("status_ovf", q_mmio, 32'h0000_0508);
    cyc(1'b1, 12'hF01, 32'h400, 1'b1, 1'b0);
    cyc(1'b1, 12'hF01, 32'h0, 1'b0, 1'b0);
    check("status_clr", q_mmio, 32'h0000_0108);

    // Push into a full FIFO while popping
    cyc(1'b1, 12'hF00, 32'h55, 1'b1, 1'b1);
    cyc(1'b1, 12'hF01, 32'h0, 1'b0, 1'b0);
    check("full_pushpop", q_mmio, 32'h0000_0108);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("last_0x55", out_data, 32'h55);
    idle(1'b1);
    check("full_drained", 32'(out_valid), 32'h0);

    // CYCLES wrap
    cyc(1'b1, 12'hF02, 32'hFFFF_FFFE, 1'b1, 1'b0);
    idle(1'b0);
    cyc(1'b1, 12'hF02, 32'h0, 1'b0, 1'b0);
    check("cyc_max", q_mmio, 32'hFFFF_FFFF);
    cyc(1'b1, 12'hF02, 32'h0, 1'b0, 1'b0);
    check("cyc_wrap", q_mmio, 32'h0);

    // Drain interrupt
    cyc(1'b1, 12'hF03, 32'h1, 1'b1, 1'b0);
    cyc(1'b1, 12'hF00, 32'h77, 1'b1, 1'b0);
    idle(1'b1);
    check("irq_lag", 32'(irq), 32'h0);
    idle(1'b0);
    check("irq_set", 32'(irq), 32'h1);
    cyc(1'b1, 12'hF00, 32'h78, 1'b1, 1'b0);
    idle(1'b0);
    check("irq_clr", 32'(irq), 32'h0);
    cyc(1'b1, 12'h100, 32'h0, 1'b0, 1'b0);
    check("oow_hit", 32'(hit), 32'h0);
    check("oow_q", q_mmio, 32'h0);

    // Flush leaves overflow alone and empties the FIFO
    cyc(1'b1, 12'hF03, 32'h2, 1'b1, 1'b1);
    check("flush_empty", 32'(out_valid), 32'h0);

    // Reset mid-drain
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'hF00, 32'h200 + i, 1'b1, 1'b0);
    cyc(1'b0, 12'hF00, 32'h99, 1'b1, 1'b1);
    check("rst_valid", 32'(out_valid), 32'h0);
    cyc(1'b1, 12'hF02, 32'h0, 1'b0, 1'b0);
    check("rst_cycles", q_mmio, 32'h0);
    cyc(1'b1, 12'hF01, 32'h0, 1'b0, 1'b0);
    check("rst_status", q_mmio, 32'h0000_0200);

    // Random traffic with shifting consumer pressure
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 200) % 3;
      rst_n = ($urandom_range(0, 99) != 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 12'hF00;
        4:          a = 12'hF01;
        5:          a = 12'hF02;
        6:          a = 12'hF03;
        7:          a = {4'hF, 8'($urandom_range(0, 255))};
        default:    a = 12'($urandom());
      endcase
      d   = $urandom();
      we  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) < phase + 1) && (phase != 0 || $urandom_range(0, 3) == 0);
      cyc(rst_n, a, d, we, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
